const_arbiter: RTL and testbench
================================

Name: const_arbiter

Overview:
- Shares the single constant ROM (one-hot 6-bit address, one-cycle registered output plus an `effective` flag) between two requesters: the pairing control FSM (port 0) and the debug/load path (port 1).
- Arbitrates round-robin and converts a 3-bit constant index into the ROM's one-hot address.
- Sequences the ROM's one-cycle read latency.
- Returns the 198-bit constant, tagged with the winning requester and an error flag, to the field-arithmetic register file write path.

Parameters:
- W, 198, constant data width; must match the ROM output width.
- AW, 6, ROM address width (one-hot).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held high until gnt0 is seen.
- sel0  input  3  requester 0 constant index: 0=zero, 1=one, 2=plus, 3=minus, 4=cubic, 5..7 invalid.
- req1  input  1  requester 1 request; same rules as req0.
- sel1  input  3  requester 1 constant index; same encoding as sel0.
- gnt0  output  1  one-cycle pulse; requester 0 accepted.
- gnt1  output  1  one-cycle pulse; requester 1 accepted.
- const_addr  output  AW  to ROM addr; one-hot 1<<sel for sel 0..4, else 0.
- const_out  input  W  from ROM out.
- const_effective  input  1  from ROM effective.
- data  output  W  captured constant; held until next capture.
- valid  output  1  one-cycle pulse; data/id/err are valid.
- id  output  1  requester that owns the current data (0 or 1).
- err  output  1  high with valid when the ROM reported effective=0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset value of every output is 0: gnt0, gnt1, const_addr, data, valid, id, err, busy.
- Reset also sets state=IDLE and last_winner=1, so requester 0 has priority first.
- Reset mid-operation aborts the transaction: no valid, no gnt is issued afterwards.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE, no request: outputs stay 0; state stays IDLE.
- IDLE, any request (edge ending cycle T):
  - Only one request: that requester wins.
  - Both requesting: the one not equal to last_winner wins.
  - On the edge: owner<=winner, last_winner<=winner, gnt_winner<=1, const_addr<=onehot(sel_winner), state<=ISSUE.
  - sel is sampled only on this edge.
- ISSUE (cycle T+1):
  - gnt and const_addr are high/stable; the ROM samples the address on this edge.
  - On the edge: gnt<=0, const_addr<=0, state<=WAIT.
- WAIT (cycle T+2):
  - const_out and const_effective reflect the issued address.
  - On the edge: data<=const_out, err<=~const_effective, id<=owner, valid<=1, state<=DONE.
- DONE (cycle T+3):
  - valid is high for exactly this cycle.
  - On the edge: valid<=0, state<=IDLE. data, id and err hold their values.
- Timing:
  - Request-sampled to valid: 3 cycles.
  - Minimum interval between grants: 4 cycles.
  - busy is high in cycles T+1..T+3.
- Requests are ignored outside IDLE. A req still high in IDLE after its own valid is treated as a new request.
- Invalid sel (5..7):
  - const_addr is driven to 0; the ROM returns out=0 and effective=0.
  - Response: valid with data=0, err=1. The grant and last_winner update happen normally.
- Index 0 (zero constant): one-hot address 1; data=0, err=0. This is distinguished from the invalid case only by err.
- No requester is starved: with both requests held continuously, grants strictly alternate.
- gnt0 and gnt1 are never high in the same cycle.
- At most one bit of const_addr is ever set.

Test Plan:
- Reset, then req0=1, sel0=1 at cycle T:
  - gnt0 high at T+1, const_addr=6'b000010 at T+1.
  - valid at T+3 with data=198'd1, id=0, err=0.
  - busy high T+1..T+3.
- req1=1, sel1=4 alone: const_addr=6'b010000; valid with data={6'b010101,192'd0}, id=1, err=0.
- req0 and req1 held continuously, sel0=2, sel1=3:
  - Grant order is 0,1,0,1, one grant every 4 cycles.
  - Data alternates {6'b000101,192'd0} / {6'b001001,192'd0}; id alternates 0/1.
- req0=1, sel0=6: const_addr stays 0; valid with data=0, err=1; the next request is served normally with err=0.
- req0=1, sel0=0: const_addr=6'b000001; valid with data=0, err=0.
- Assert reset in the WAIT cycle of a transaction: the following cycle shows all outputs 0 and state IDLE; no valid ever appears for the aborted transaction.
- Assert reset in the WAIT cycle, then raise req0 and req1 together: gnt0 wins, confirming priority was reset.

Source files
------------

// File: rtl/const_arbiter.sv
// const_arbiter
//   Shares the single constant ROM between two requesters (port 0: pairing
//   control FSM, port 1: debug/load path). A round-robin winner is picked in
//   IDLE, its 3-bit constant index is turned into the ROM's one-hot address,
//   the ROM's one-cycle read latency is sequenced, and the constant is
//   returned tagged with the owner id and an error flag.
//
//   Handshake: a requester raises reqN with selN and holds req high until it
//   sees the one-cycle gntN pulse. sel is sampled only on the grant edge.
//   Requests are ignored outside IDLE. The response is a one-cycle valid
//   pulse qualifying data/id/err. data/id/err then hold until the next
//   capture. There is no back-pressure on the response.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   req0/sel0        requester 0 request and constant index
//   req1/sel1        requester 1 request and constant index
//   gnt0/gnt1        one-cycle grant pulses
//   const_addr       one-hot ROM address (0 for invalid index)
//   const_out        ROM data, registered inside the ROM
//   const_effective  ROM flag, 0 when the address selected nothing
//   data/valid/id/err  response to the register file write path
//   busy             high in every state except IDLE
//   dbg_state        current FSM state for observation
module const_arbiter #(
    parameter int W  = 198,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [2:0]    sel0,
    input  logic          req1,
    input  logic [2:0]    sel1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [AW-1:0] const_addr,
    input  logic [W-1:0]  const_out,
    input  logic          const_effective,
    output logic [W-1:0]  data,
    output logic          valid,
    output logic          id,
    output logic          err,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic          last_winner;
    logic          owner;
    logic          win1;
    logic [2:0]    win_sel;
    logic [AW-1:0] addr_next;

    // Requester 1 wins when it is alone, or when both request and
    // requester 0 took the previous grant.
    always_comb begin
        win1      = req1 & (~req0 | ~last_winner);
        win_sel   = win1 ? sel1 : sel0;
        addr_next = '0;
        if (win_sel <= 3'd4) begin
            addr_next = AW'(1) << win_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_winner <= 1'b1;
            owner       <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            const_addr  <= '0;
            data        <= '0;
            valid       <= 1'b0;
            id          <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        owner       <= win1;
                        last_winner <= win1;
                        gnt0        <= ~win1;
                        gnt1        <= win1;
                        const_addr  <= addr_next;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // ROM samples const_addr on this edge.
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
                    const_addr <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    data  <= const_out;
                    err   <= ~const_effective;
                    id    <= owner;
                    valid <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_const_arbiter.sv
module tb_const_arbiter;

    localparam int W  = 198;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0;
    logic [2:0]    sel0 = 3'd0;
    logic          req1 = 1'b0;
    logic [2:0]    sel1 = 3'd0;
    logic          gnt0, gnt1;
    logic [AW-1:0] const_addr;
    logic [W-1:0]  const_out;
    logic          const_effective;
    logic [W-1:0]  data;
    logic          valid, id, err, busy;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    bit m_last = 1'b1;           // model: requester that took the last grant
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_data;

    const_arbiter #(.W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .sel0(sel0), .req1(req1), .sel1(sel1),
        .gnt0(gnt0), .gnt1(gnt1), .const_addr(const_addr),
        .const_out(const_out), .const_effective(const_effective),
        .data(data), .valid(valid), .id(id), .err(err), .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // constant table indexed by the requester's index
    function automatic logic [W-1:0] exp_const(input logic [2:0] s);
        case (s)
            3'd0:    exp_const = '0;
            3'd1:    exp_const = 198'd1;
            3'd2:    exp_const = {6'b000101, 192'd0};
            3'd3:    exp_const = {6'b001001, 192'd0};
            3'd4:    exp_const = {6'b010101, 192'd0};
            default: exp_const = '0;
        endcase
    endfunction

    // behavioural ROM, keyed by one-hot address, one-cycle registered
    always @(posedge clk) begin
        case (const_addr)
            6'b000001: begin const_out <= '0;                  const_effective <= 1'b1; end
            6'b000010: begin const_out <= 198'd1;              const_effective <= 1'b1; end
            6'b000100: begin const_out <= {6'b000101, 192'd0}; const_effective <= 1'b1; end
            6'b001000: begin const_out <= {6'b001001, 192'd0}; const_effective <= 1'b1; end
            6'b010000: begin const_out <= {6'b010101, 192'd0}; const_effective <= 1'b1; end
            default:   begin const_out <= '0;                  const_effective <= 1'b0; end
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt0"},  W'(gnt0), '0);
        chk({tag, ".gnt1"},  W'(gnt1), '0);
        chk({tag, ".addr"},  W'(const_addr), '0);
        chk({tag, ".data"},  data, '0);
        chk({tag, ".valid"}, W'(valid), '0);
        chk({tag, ".id"},    W'(id), '0);
        chk({tag, ".err"},   W'(err), '0);
        chk({tag, ".busy"},  W'(busy), '0);
        chk({tag, ".state"}, W'(dbg_state), '0);
    endtask

    // driver: present requests in an IDLE cycle and follow one transaction
    task automatic run_txn(input bit r0, input logic [2:0] s0,
                           input bit r1, input logic [2:0] s1,
                           input bit keep, output bit w);
        logic [2:0]    ws;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        @(negedge clk);
        req0 = r0; sel0 = s0; req1 = r1; sel1 = s1;
        w      = (r0 && r1) ? ~m_last : !r0;
        m_last = w;
        ws     = w ? s1 : s0;
        ea     = (ws <= 3'd4) ? (AW'(1) << ws) : '0;
        exp_q.push_back(exp_const(ws));
        @(posedge clk); #1;                       // T+1
        chk("issue.gnt0",  W'(gnt0), W'(!w));
        chk("issue.gnt1",  W'(gnt1), W'(w));
        chk("issue.addr",  W'(const_addr), W'(ea));
        chk("issue.busy",  W'(busy), W'(1'b1));
        chk("issue.valid", W'(valid), '0);
        if (!keep) begin
            if (w) req1 = 1'b0; else req0 = 1'b0;
        end
        @(posedge clk); #1;                       // T+2
        chk("wait.gnt",   W'(gnt0 | gnt1), '0);
        chk("wait.addr",  W'(const_addr), '0);
        chk("wait.busy",  W'(busy), W'(1'b1));
        chk("wait.valid", W'(valid), '0);
        @(posedge clk); #1;                       // T+3
        ed = exp_q.pop_front();
        last_data = ed;
        chk("done.valid", W'(valid), W'(1'b1));
        chk("done.data",  data, ed);
        chk("done.id",    W'(id), W'(w));
        chk("done.err",   W'(err), W'(ws > 3'd4));
        chk("done.busy",  W'(busy), W'(1'b1));
        chk("done.gnt",   W'(gnt0 | gnt1), '0);
        @(posedge clk); #1;                       // back in IDLE
        chk("idle.valid", W'(valid), '0);
        chk("idle.busy",  W'(busy), '0);
        chk("idle.data",  data, ed);
        chk("idle.state", W'(dbg_state), '0);
    endtask

    initial begin
        bit w;
        bit p0, p1;
        logic [2:0] rs0, rs1;

        // reset state
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1 chk_all_zero("idle_noreq");
        end

        // directed: single requests
        run_txn(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, w);
        run_txn(1'b0, 3'd0, 1'b1, 3'd4, 1'b0, w);

        // both held continuously: strict alternation
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, w);
            chk("alt.order", W'(w), W'(i[0]));
        end

        // invalid index, then normal, then the zero constant
        run_txn(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, w);
        run_txn(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, w);
        run_txn(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, w);

        // reset during WAIT aborts the transaction
        @(negedge clk);
        req0 = 1'b1; sel0 = 3'd3; req1 = 1'b0;
        @(posedge clk); #1;
        chk("abort.gnt0", W'(gnt0), W'(1'b1));
        req0 = 1'b0;
        @(posedge clk); #1;                       // WAIT cycle
        chk("abort.state_wait", W'(dbg_state), W'(2'd2));
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("abort");
        reset = 1'b0;
        m_last = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("abort.novalid", W'(valid | gnt0 | gnt1 | busy), '0);
        end

        // priority restored: both together, requester 0 wins
        run_txn(1'b1, 3'd4, 1'b1, 3'd2, 1'b0, w);
        chk("abort.prio", W'(w), '0);

        // randomized traffic; a losing requester keeps its request
        p0 = 1'b0; p1 = 1'b1; rs0 = 3'd0; rs1 = 3'd2;   // requester 1 still pending
        for (int i = 0; i < 40; i++) begin
            if (!p0) begin p0 = 1'($urandom_range(0, 1)); rs0 = 3'($urandom_range(0, 7)); end
            if (!p1) begin p1 = 1'($urandom_range(0, 1)); rs1 = 3'($urandom_range(0, 7)); end
            if (!p0 && !p1) begin p0 = 1'b1; rs0 = 3'($urandom_range(0, 7)); end
            run_txn(p0, rs0, p1, rs1, 1'b0, w);
            if (w) p1 = 1'b0; else p0 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("tail.idle", W'(valid | busy | gnt0 | gnt1), '0);
            chk("tail.hold", data, last_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
